sub_calc_ctrl: RTL

SUB_CALC_CTRL -- requirements
Module: sub_calc_ctrl

---
 rtl/sub_calc_ctrl_if.sv | 33 +++
 rtl/sub_calc_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/sub_calc_ctrl_if.sv
// Keypad, subtractor and result signals of the two-operand BCD subtract controller.
// master = keypad/subtractor side, slave = controller side.
interface sub_calc_ctrl_if;
   // Key inputs are single-cycle pulses with no back-pressure: a pulse is consumed
   // (or dropped) on the rising edge where it is high; done is a one-cycle pulse.
   logic       digit_vld;
   logic [3:0] digit;
   logic       minus_p;
   logic       equal_p;
   logic       clear_p;
   logic       sub_sign;
   logic [3:0] sub_hi;
   logic [3:0] sub_lo;
   logic [3:0] a_hi;
   logic [3:0] a_lo;
   logic [3:0] b_hi;
   logic [3:0] b_lo;
   logic       res_sign;
   logic [3:0] res_hi;
   logic [3:0] res_lo;
   logic       done;
   logic [1:0] state;

   modport master (
      output digit_vld, digit, minus_p, equal_p, clear_p, sub_sign, sub_hi, sub_lo,
      input  a_hi, a_lo, b_hi, b_lo, res_sign, res_hi, res_lo, done, state
   );

   modport slave (
      input  digit_vld, digit, minus_p, equal_p, clear_p, sub_sign, sub_hi, sub_lo,
      output a_hi, a_lo, b_hi, b_lo, res_sign, res_hi, res_lo, done, state
   );
endinterface

// File: rtl/sub_calc_ctrl.sv
// Keypad controller for a 2-digit BCD subtract calculator: collects operands A and B,
// waits for an external subtractor to settle, then captures and holds its result.
module sub_calc_ctrl #(
   parameter int CALC_WAIT = 1
) (
   input  logic           clk,
   input  logic           rst,
   sub_calc_ctrl_if.slave bus
);

   typedef enum logic [1:0] {S_A = 2'd0, S_B = 2'd1, S_WAIT = 2'd2, S_SHOW = 2'd3} state_e;

   // The counter starts at 0 on the equal edge, so capture happens on the edge where it
   // has reached CALC_WAIT, giving CALC_WAIT+1 edges from equal to valid result.
   localparam logic [3:0] CNT_LAST = 4'(CALC_WAIT);

   state_e     state_q, state_d;
   logic [3:0] a_hi_q, a_hi_d, a_lo_q, a_lo_d;
   logic [3:0] b_hi_q, b_hi_d, b_lo_q, b_lo_d;
   logic       res_sign_q, res_sign_d;
   logic [3:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
   logic       done_q, done_d;
   logic [3:0] cnt_q, cnt_d;
   logic       digit_ok;

   assign digit_ok = bus.digit_vld && (bus.digit <= 4'd9);

   always_comb begin
      state_d    = state_q;
      a_hi_d     = a_hi_q;
      a_lo_d     = a_lo_q;
      b_hi_d     = b_hi_q;
      b_lo_d     = b_lo_q;
      res_sign_d = res_sign_q;
      res_hi_d   = res_hi_q;
      res_lo_d   = res_lo_q;
      cnt_d      = cnt_q;
      done_d     = 1'b0;

      if (bus.clear_p) begin
         state_d    = S_A;
         a_hi_d     = 4'd0;
         a_lo_d     = 4'd0;
         b_hi_d     = 4'd0;
         b_lo_d     = 4'd0;
         res_sign_d = 1'b0;
         res_hi_d   = 4'd0;
         res_lo_d   = 4'd0;
         cnt_d      = 4'd0;
      end else if (state_q == S_WAIT) begin
         // Operands are frozen and every other key is dropped while the subtractor settles.
         if (cnt_q == CNT_LAST) begin
            res_sign_d = bus.sub_sign;
            res_hi_d   = bus.sub_hi;
            res_lo_d   = bus.sub_lo;
            done_d     = 1'b1;
            state_d    = S_SHOW;
         end else begin
            cnt_d = cnt_q + 4'd1;
         end
      end else if (bus.equal_p) begin
         if (state_q == S_B) begin
            state_d = S_WAIT;
            cnt_d   = 4'd0;
         end
      end else if (bus.minus_p) begin
         if (state_q == S_A) begin
            b_hi_d  = 4'd0;
            b_lo_d  = 4'd0;
            state_d = S_B;
         end else if (state_q == S_SHOW && !res_sign_q) begin
            a_hi_d  = res_hi_q;
            a_lo_d  = res_lo_q;
            b_hi_d  = 4'd0;
            b_lo_d  = 4'd0;
            state_d = S_B;
         end
      end else if (digit_ok) begin
         case (state_q)
            S_A: begin
               a_hi_d = a_lo_q;
               a_lo_d = bus.digit;
            end
            S_B: begin
               b_hi_d = b_lo_q;
               b_lo_d = bus.digit;
            end
            S_SHOW: begin
               a_hi_d  = 4'd0;
               a_lo_d  = bus.digit;
               b_hi_d  = 4'd0;
               b_lo_d  = 4'd0;
               state_d = S_A;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_A;
         a_hi_q     <= 4'd0;
         a_lo_q     <= 4'd0;
         b_hi_q     <= 4'd0;
         b_lo_q     <= 4'd0;
         res_sign_q <= 1'b0;
         res_hi_q   <= 4'd0;
         res_lo_q   <= 4'd0;
         done_q     <= 1'b0;
         cnt_q      <= 4'd0;
      end else begin
         state_q    <= state_d;
         a_hi_q     <= a_hi_d;
         a_lo_q     <= a_lo_d;
         b_hi_q     <= b_hi_d;
         b_lo_q     <= b_lo_d;
         res_sign_q <= res_sign_d;
         res_hi_q   <= res_hi_d;
         res_lo_q   <= res_lo_d;
         done_q     <= done_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.a_hi     = a_hi_q;
   assign bus.a_lo     = a_lo_q;
   assign bus.b_hi     = b_hi_q;
   assign bus.b_lo     = b_lo_q;
   assign bus.res_sign = res_sign_q;
   assign bus.res_hi   = res_hi_q;
   assign bus.res_lo   = res_lo_q;
   assign bus.done     = done_q;
   assign bus.state    = state_q;

endmodule
